fsk_demodulator: RTL and testbench

Receive-side counterpart of the 16-tone FSK modulator. It hunts for the constant-level sync preamble on the 18-bit sine sample stream and then measures fixed-length symbol windows. Each window's tone index is recovered by counting hysteresis-qualified rising zero crossings. The block sits between the sample source (modulator loopback or ADC path) and the symbol sink, and emits one 4-bit symbol per window.

---
 rtl/fsk_demod_pkg.sv | 30 +++
 rtl/fsk_demodulator_zero_cross.sv | 51 +++++
 rtl/fsk_demodulator.sv | 123 ++++++++++++
 tb/tb_fsk_demodulator.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fsk_demod_pkg.sv
// Shared types and helpers for the FSK demodulator.
// Holds the FSM state encoding and the symbol rounding/clamp function.
package fsk_demod_pkg;

  typedef enum logic [1:0] {HUNT, SYNC, MEASURE} state_e;

  localparam logic [17:0] SYNC_VALUE_DEF = 18'h0FFFF;
  localparam int          NUM_TONES      = 16;

  typedef struct packed {
    logic       err;
    logic [3:0] data;
  } sym_t;

  // Round crossing count to the nearest tone step, then map 1..NUM_TONES onto 0..15.
  function automatic sym_t round_clamp(input logic [31:0] count,
                                       input int unsigned step_log2);
    logic [31:0] r;
    sym_t        s;
    r = (count + (32'd1 << (step_log2 - 1))) >> step_log2;
    if (r == 32'd0)
      s = '{err: 1'b1, data: 4'd0};
    else if (r > 32'(NUM_TONES))
      s = '{err: 1'b1, data: 4'(NUM_TONES - 1)};
    else
      s = '{err: 1'b0, data: 4'(r - 32'd1)};
    return s;
  endfunction

endpackage

// File: rtl/fsk_demodulator_zero_cross.sv
// Hysteresis-qualified rising zero-crossing counter for one sample stream.
// count_next includes the current sample, so the window-final sample can be scored directly.
module fsk_zero_cross
  import fsk_demod_pkg::*;
#(
  parameter int SAMPLE_W = 18,
  parameter int HYST     = 1024,
  parameter int CNT_W    = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [SAMPLE_W-1:0] sample,
  input  logic                       valid,
  input  logic                       clear_count,
  input  logic                       clear_armed,
  output logic        [CNT_W-1:0]    count_next
);

  localparam logic signed [SAMPLE_W-1:0] POS_TH = SAMPLE_W'(HYST);
  localparam logic signed [SAMPLE_W-1:0] NEG_TH = SAMPLE_W'(-HYST);

  logic             armed_q, armed_d, armed_base;
  logic [CNT_W-1:0] cnt_q, cnt_base;

  // Clears apply to the base value, so the current sample is still counted on top.
  always_comb begin
    armed_base = clear_armed ? 1'b0 : armed_q;
    cnt_base   = clear_count ? '0 : cnt_q;
    armed_d    = armed_base;
    count_next = cnt_base;
    if (valid) begin
      if (armed_base && (sample >= POS_TH)) begin
        armed_d = 1'b0;
        if (cnt_base != '1) count_next = cnt_base + 1'b1;
      end else if (sample < NEG_TH) begin
        armed_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      armed_q <= armed_d;
      cnt_q   <= count_next;
    end
  end

endmodule

// File: rtl/fsk_demodulator.sv
// 16-tone FSK receiver: locks on the constant preamble, then emits one symbol
// per fixed window from the rounded rising-zero-crossing count.
module fsk_demodulator
  import fsk_demod_pkg::*;
#(
  parameter int                    SAMPLE_W   = 18,
  parameter logic [SAMPLE_W-1:0]   SYNC_VALUE = SAMPLE_W'(SYNC_VALUE_DEF),
  parameter int                    SYNC_MIN   = 8,
  parameter int                    WINDOW     = 800,
  parameter int                    STEP_LOG2  = 3,
  parameter int                    HYST       = 1024,
  parameter int                    CNT_W      = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  output logic [3:0]          data_out,
  output logic                data_valid,
  output logic                sym_err,
  output logic                locked
);

  localparam int RUN_W = $clog2(SYNC_MIN + 1);

  state_e           state_q, state_d;
  logic [RUN_W-1:0] sync_run_q, sync_run_d;
  logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
  logic [3:0]       data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             sym_err_q, sym_err_d;

  logic             is_sync, sync_hit, zc_valid;
  logic [CNT_W-1:0] zc_count_next;
  sym_t             sym;

  assign is_sync = (sample_in == SYNC_VALUE);

  fsk_zero_cross #(
    .SAMPLE_W (SAMPLE_W),
    .HYST     (HYST),
    .CNT_W    (CNT_W)
  ) u_zc (
    .clk         (clk),
    .reset       (reset),
    .sample      ($signed(sample_in)),
    .valid       (zc_valid),
    .clear_count (win_cnt_q == '0),
    .clear_armed (state_q != MEASURE),
    .count_next  (zc_count_next)
  );

  always_comb begin
    sync_run_d = sync_run_q;
    if (sample_valid) begin
      if (!is_sync)                              sync_run_d = '0;
      else if (sync_run_q != RUN_W'(SYNC_MIN))   sync_run_d = sync_run_q + 1'b1;
    end
    sync_hit = sample_valid && is_sync && (sync_run_d == RUN_W'(SYNC_MIN));
  end

  always_comb begin
    state_d      = state_q;
    win_cnt_d    = win_cnt_q;
    data_out_d   = data_out_q;
    sym_err_d    = sym_err_q;
    data_valid_d = 1'b0;
    zc_valid     = 1'b0;
    sym          = round_clamp(32'(zc_count_next), 32'(STEP_LOG2));
    case (state_q)
      HUNT: if (sync_hit) state_d = SYNC;
      SYNC: begin
        // First non-preamble sample opens the window as its sample 1.
        if (sample_valid && !is_sync) begin
          state_d   = MEASURE;
          win_cnt_d = CNT_W'(1);
          zc_valid  = 1'b1;
        end
      end
      MEASURE: begin
        if (sample_valid) begin
          zc_valid = 1'b1;
          if (sync_hit) begin
            state_d   = SYNC;
            win_cnt_d = '0;
          end else if (win_cnt_q == CNT_W'(WINDOW - 1)) begin
            win_cnt_d    = '0;
            data_valid_d = 1'b1;
            data_out_d   = sym.data;
            sym_err_d    = sym.err;
          end else begin
            win_cnt_d = win_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= HUNT;
      sync_run_q   <= '0;
      win_cnt_q    <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      sym_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_run_q   <= sync_run_d;
      win_cnt_q    <= win_cnt_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      sym_err_q    <= sym_err_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign sym_err    = sym_err_q;
  assign locked     = (state_q == MEASURE);

endmodule

// File: tb/tb_fsk_demodulator.sv
// Directed bench for fsk_demodulator: table of single-symbol scenarios plus
// hand sequences for tone sweep, resync abort and asynchronous reset.
module tb_fsk_demodulator;

  localparam logic [17:0] SYNCV = 18'h0FFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic [17:0] sample_in;
  logic        sample_valid;
  logic [3:0]  data_out;
  logic        data_valid, sym_err, locked;

  always #5 clk = ~clk;

  fsk_demodulator dut (
    .clk          (clk),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .sym_err      (sym_err),
    .locked       (locked)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  int         dv_cnt   = 0;
  logic [3:0] last_data = '0;
  logic       last_err  = 1'b0;
  int         ph = 0;

  always @(negedge clk) begin
    if (data_valid) begin
      dv_cnt    = dv_cnt + 1;
      last_data = data_out;
      last_err  = sym_err;
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [17:0] sine(input int p);
    real v;
    v = 16383.0 * $sin(6.283185307179586 * real'(p) / 65536.0);
    return 18'($rtoi(v));
  endfunction

  function automatic int tone_inc(input int k);
    return $rtoi(655.36 * real'(k + 1) + 0.5);
  endfunction

  task automatic drive(input logic [17:0] s, input logic v);
    @(negedge clk);
    sample_in    = s;
    sample_valid = v;
  endtask

  task automatic preamble(input int n);
    repeat (n) drive(SYNCV, 1'b1);
  endtask

  task automatic tone(input int k, input int n, input bit half);
    for (int i = 0; i < n; i++) begin
      drive(sine(ph), 1'b1);
      ph = (ph + tone_inc(k)) & 32'hFFFF;
      if (half) drive(SYNCV, 1'b0);  // preamble value while invalid must be ignored
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(18'($urandom), 1'b0);
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    sample_valid = 1'b0;
    sample_in    = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ph    = 0;
  endtask

  typedef struct {
    int pre;
    int kind;      // 0 tone, 1 constant zero
    int tnum;
    bit half;
    int exp_dv;
    int exp_data;
    int exp_err;
    int exp_lock;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int start;
    vecs[0] = '{11, 0, 0,  1'b0, 1, 0,  0, 1};
    vecs[1] = '{5,  0, 5,  1'b0, 0, 0,  0, 0};
    vecs[2] = '{11, 1, 0,  1'b0, 1, 0,  1, 1};
    vecs[3] = '{11, 0, 7,  1'b1, 1, 7,  0, 1};
    vecs[4] = '{8,  0, 12, 1'b0, 1, 12, 0, 1};

    reset = 1'b1; sample_valid = 1'b0; sample_in = '0;
    #1;
    check("rst_data_out", int'(data_out), 0);
    check("rst_data_valid", int'(data_valid), 0);
    check("rst_sym_err", int'(sym_err), 0);
    check("rst_locked", int'(locked), 0);
    do_reset();

    for (int v = 0; v < 5; v++) begin
      do_reset();
      start = dv_cnt;
      preamble(vecs[v].pre);
      for (int i = 0; i < 800; i++) begin
        if (vecs[v].kind == 1) drive(18'd0, 1'b1);
        else begin
          drive(sine(ph), 1'b1);
          ph = (ph + tone_inc(vecs[v].tnum)) & 32'hFFFF;
          if (vecs[v].half) drive(SYNCV, 1'b0);
        end
      end
      @(negedge clk);
      sample_valid = 1'b0;
      if (vecs[v].exp_dv != 0 && !vecs[v].half)
        check($sformatf("vec%0d_latency", v), int'(data_valid), 1);
      idle(5);
      check($sformatf("vec%0d_dv_count", v), dv_cnt - start, vecs[v].exp_dv);
      if (vecs[v].exp_dv != 0) begin
        check($sformatf("vec%0d_data", v), int'(last_data), vecs[v].exp_data);
        check($sformatf("vec%0d_err", v), int'(last_err), vecs[v].exp_err);
      end
      check($sformatf("vec%0d_locked", v), int'(locked), vecs[v].exp_lock);
    end

    // Tone sweep, back to back with continuous phase.
    do_reset();
    start = dv_cnt;
    preamble(11);
    for (int k = 0; k < 16; k++) begin
      tone(k, 800, 1'b0);
      @(negedge clk);
      sample_valid = 1'b0;
      check($sformatf("sweep%0d_dv", k), int'(data_valid), 1);
      check($sformatf("sweep%0d_data", k), int'(data_out), k);
      check($sformatf("sweep%0d_err", k), int'(sym_err), 0);
    end
    idle(3);
    check("sweep_dv_count", dv_cnt - start, 16);

    // Resync abort mid-window.
    do_reset();
    start = dv_cnt;
    preamble(11);
    tone(3, 400, 1'b0);
    preamble(10);
    @(negedge clk);
    sample_valid = 1'b0;
    check("resync_locked_low", int'(locked), 0);
    check("resync_no_symbol", dv_cnt - start, 0);
    ph = 0;
    tone(9, 800, 1'b0);
    @(negedge clk);
    sample_valid = 1'b0;
    check("resync_dv", int'(data_valid), 1);
    check("resync_data", int'(data_out), 9);
    check("resync_locked", int'(locked), 1);
    idle(3);
    check("resync_dv_count", dv_cnt - start, 1);

    // Asynchronous reset mid-window after a completed symbol.
    do_reset();
    preamble(11);
    tone(4, 900, 1'b0);
    @(negedge clk);
    sample_valid = 1'b0;
    check("pre_reset_data", int'(data_out), 4);
    check("pre_reset_locked", int'(locked), 1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_data_out", int'(data_out), 0);
    check("async_rst_locked", int'(locked), 0);
    check("async_rst_sym_err", int'(sym_err), 0);
    check("async_rst_data_valid", int'(data_valid), 0);
    @(negedge clk);
    reset = 1'b0;
    start = dv_cnt;
    tone(4, 1000, 1'b0);
    idle(3);
    check("no_preamble_dv", dv_cnt - start, 0);
    check("no_preamble_locked", int'(locked), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
